// File: rtl/downsizing_if.sv
// downsizing_if: wide-in / narrow-out AXI-Stream bundle.
// master = upstream+downstream driver side, slave = converter side.
interface downsizing_if #(
  parameter int NB = 40
);
  logic [2*NB-1:0] in_tdata;
  logic            in_tvalid;
  logic            in_tready;
  logic [NB-1:0]   out_tdata;
  logic            out_tvalid;
  logic            out_tready;

  modport master (
    output in_tdata, in_tvalid, out_tready,
    input  in_tready, out_tdata, out_tvalid
  );

  modport slave (
    input  in_tdata, in_tvalid, out_tready,
    output in_tready, out_tdata, out_tvalid
  );
endinterface

// File: rtl/downsizing.sv
// downsizing: 2:1 AXI-Stream width halver, upper half first.
// Ports: aclk, aresetn (async low), bus (slave). Option: DOWNSIZING_SKID_EN.
module downsizing #(
  parameter int n  = 5,
  parameter int nb = n*8
) (
  input  logic         aclk,
  input  logic         aresetn,
  downsizing_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HI   = 2'd1,
    LO   = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nx;
  logic [2*nb-1:0] r_data;
  logic [2*nb-1:0] w_data_nx;
  logic [nb-1:0]   w_out_data;
  logic            w_in_rdy;
  logic            w_in_xfer;
  logic            w_out_xfer;

`ifdef DOWNSIZING_SKID_EN
  logic [2*nb-1:0] r_skid;
  logic [2*nb-1:0] w_skid_nx;
  logic            r_full;
  logic            w_full_nx;
  logic            r_rdy;

  assign w_in_rdy = r_rdy;
`else
  // r_en keeps in_tready low until the first edge after reset release
  logic            r_en;

  assign w_in_rdy = aresetn & r_en &
                    ((r_state == IDLE) |
                     ((r_state == LO) & bus.out_tready));
`endif

  assign w_in_xfer  = bus.in_tvalid & w_in_rdy;
  assign w_out_xfer = (r_state != IDLE) & bus.out_tready;

  always_comb begin
    w_state_nx = r_state;
    w_data_nx  = r_data;
`ifdef DOWNSIZING_SKID_EN
    w_skid_nx  = r_skid;
    w_full_nx  = r_full;
`endif
    unique case (r_state)
      IDLE: begin
        if (w_in_xfer) begin
          w_state_nx = HI;
          w_data_nx  = bus.in_tdata;
        end
      end
      HI: begin
        if (w_out_xfer) w_state_nx = LO;
      end
      LO: begin
        if (w_out_xfer) begin
`ifdef DOWNSIZING_SKID_EN
          if (r_full) begin
            w_state_nx = HI;
            w_data_nx  = r_skid;
            w_full_nx  = 1'b0;
          end else if (w_in_xfer) begin
            w_state_nx = HI;
            w_data_nx  = bus.in_tdata;
          end else begin
            w_state_nx = IDLE;
          end
`else
          if (w_in_xfer) begin
            w_state_nx = HI;
            w_data_nx  = bus.in_tdata;
          end else begin
            w_state_nx = IDLE;
          end
`endif
        end
      end
      default: w_state_nx = IDLE;
    endcase
`ifdef DOWNSIZING_SKID_EN
    // in_tready implies skid empty, so an accepted word in HI, or in LO
    // without the final beat leaving, must park in the skid register
    if (w_in_xfer &&
        ((r_state == HI) ||
         ((r_state == LO) && !w_out_xfer))) begin
      w_skid_nx = bus.in_tdata;
      w_full_nx = 1'b1;
    end
`endif
  end

  always_comb begin
    w_out_data = '0;
    unique case (r_state)
      HI:      w_out_data = r_data[2*nb-1:nb];
      LO:      w_out_data = r_data[nb-1:0];
      default: w_out_data = '0;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= IDLE;
      r_data  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_data  <= w_data_nx;
    end
  end

`ifdef DOWNSIZING_SKID_EN
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_skid <= '0;
      r_full <= 1'b0;
      r_rdy  <= 1'b0;
    end else begin
      r_skid <= w_skid_nx;
      r_full <= w_full_nx;
      r_rdy  <= ~w_full_nx;
    end
  end
`else
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_en <= 1'b0;
    else          r_en <= 1'b1;
  end
`endif

  assign bus.in_tready  = w_in_rdy;
  assign bus.out_tvalid = (r_state != IDLE);
  assign bus.out_tdata  = w_out_data;

endmodule

// File: doc/downsizing.md
# downsizing

Width-halving AXI-Stream converter: accepts one `nb*2`-bit word and emits it as two `nb`-bit beats, upper half first, then lower half. It is the inverse of the 2:1 upsizer in the same cascade. A word split by this block and then re-packed by the upsizer comes back bit-identical. Output is registered, and full throughput is sustained: one wide word every two cycles, one narrow beat every cycle.

## Interface
Parameters:
- `n`, default 5: bytes per narrow beat.
- `nb`, default `n*8`: narrow beat width in bits. Input width is `nb*2`.

Ports:
- `aclk` input 1: single clock; all logic on its rising edge.
- `aresetn` input 1: reset, asynchronous and active-low.
- `in_tdata` input `nb*2`: wide word. Bits `[nb*2-1:nb]` are the first beat; bits `[nb-1:0]` are the second.
- `in_tvalid` input 1: wide word valid.
- `in_tready` output 1: block accepts a wide word.
- `out_tdata` output `nb`: narrow beat.
- `out_tvalid` output 1: narrow beat valid.
- `out_tready` input 1: downstream accepts a beat.

## Operation
- Transfers:
  - Input transfer: `in_tvalid & in_tready` on a rising edge.
  - Output transfer: `out_tvalid & out_tready` on a rising edge.
- State machine:
  - IDLE: no word held; `out_tvalid`=0.
  - HI: word held; `out_tdata` = upper half.
  - LO: word held; `out_tdata` = lower half.
- Transitions:
  - IDLE→HI on input transfer.
  - HI→LO on output transfer.
  - LO→HI on output transfer with a simultaneous input transfer, or when a word is waiting in the skid buffer (skid option only).
  - LO→IDLE on output transfer with no new word.
  - With no output transfer, the state holds.
- Data register:
  - `nb*2` bits, loaded only on entry to HI.
  - Never modified while in HI or LO without an output transfer.
- `out_tvalid` is 1 in HI and LO, 0 in IDLE. `out_tdata` is a mux of the data register selected by state, so it is registered data with no combinational path from `in_tdata`.
- AXI rules:
  - Once `out_tvalid` is asserted, it and `out_tdata` stay stable until the output transfer.
  - The block never withdraws `out_tvalid`.
  - Upstream violation of `in_tvalid` stability is not checked.
- Reset (asynchronous, `aresetn`=0):
  - State goes to IDLE; data register and skid register go to 0.
  - `out_tvalid`=0, `out_tdata`=0, `in_tready`=0.
  - A word held mid-split (HI or LO) is discarded; no partial beat appears after reset.

## Timing
- Latency: a word accepted at edge N gives the upper beat valid after N and the lower beat valid after N+1, with `out_tready`=1.
- Throughput: back-to-back words with `out_tready` held at 1 produce `out_tvalid`=1 every cycle, with no bubble between the LO and HI beats.
- Backpressure: with `out_tready`=0, the current beat is held indefinitely.
- After reset release, `in_tready` first rises after the first `aclk` edge.
- `in_tready` depends on the configuration option below.

## Configuration
- Macro: `DOWNSIZING_SKID_EN`.
- Undefined (default):
  - `in_tready` is combinational: `aresetn & (IDLE | (LO & out_tready))`.
  - No extra storage.
  - `out_tready` has a combinational path to `in_tready`.
- Defined:
  - Adds one `nb*2`-bit skid register with a full flag, reset to empty.
  - `in_tready` is a flop equal to skid-empty, reset 0. There is no combinational path from `out_tready` to `in_tready`.
  - A word accepted while in HI or LO goes into the skid register. It is loaded into the data register on the LO→HI transition, and the skid register is emptied on that same edge.
  - A word accepted in IDLE, or in LO on the final beat with skid empty, goes directly to the data register.
  - Throughput and output ordering are identical to the undefined case.

## Test plan
Defaults `n`=5, `nb`=40 for all scenarios.
- Single word: `in_tdata`=80'h0102030405_A1A2A3A4A5, `out_tready`=1. Response: beats 40'h0102030405 then 40'hA1A2A3A4A5 on consecutive cycles, then `out_tvalid`=0.
- Streaming: 8 words 80'h{i,i+100} driven back-to-back, `out_tready`=1. Response: 16 beats, `out_tvalid` continuously 1, order hi0, lo0, hi1, lo1, …
- Backpressure: `out_tready` toggled randomly, 50% duty, over 200 words. Response: upsizer loopback reproduces every word exactly; `out_tdata` stable whenever `out_tvalid & ~out_tready`.
- Stall in HI: hold `out_tready`=0 for 10 cycles after acceptance. Response: `out_tdata`=upper half stable; `in_tready`=0 (undefined), or `in_tready` drops to 0 after one skid word (defined).
- Mid-split reset: assert `aresetn`=0 while in LO. Response: `out_tvalid`, `out_tdata` and `in_tready` are 0 immediately (asynchronously); the next word after release splits correctly.
- Skid path, defined only: hold `out_tready`=0 and present words W0 and W1. Response: W1 is accepted into the skid register; on release, beats come out as hi0, lo0, hi1, lo1 with no bubble.
